// File: rtl/c3_capture_stage.sv
// c3_capture_stage: registered capture of the c3 combinational outputs
// {nx33,nx44,nx12}, buffered in a first-word-fall-through FIFO and handed
// downstream over valid/ready. Samples that arrive while the FIFO is full
// and not draining are dropped and counted.
module c3_capture_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     tau2015_clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     nx33,
    input  logic                     nx44,
    input  logic                     nx12,
    input  logic                     clr_ovf,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [2:0]               out_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             vld_p1;
    logic [2:0]       cap_data_p1;
    logic [2:0]       mem_p2 [DEPTH];
    logic [PTR_W-1:0] wr_ptr_p2;
    logic [PTR_W-1:0] rd_ptr_p2;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign full = (fifo_count == FULL_CNT);
    assign pop  = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = vld_p1 & (~full | pop);
    assign drop = vld_p1 & full & ~pop;

    // ---- Stage 1: capture the c3 outputs every edge, no backpressure ----
    // Capture register loads unconditionally; valid follows in_valid.
    always_ff @(posedge tau2015_clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            cap_data_p1 <= 3'b000;
        end else begin
            vld_p1      <= in_valid;
            cap_data_p1 <= {nx33, nx44, nx12};
        end
    end

    // ---- Stage 2: FIFO storage, pointers and occupancy ----
    // Storage array is data only; occupancy decides what is visible.
    always_ff @(posedge tau2015_clk) begin
        if (push) begin
            mem_p2[wr_ptr_p2] <= cap_data_p1;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks push/pop balance.
    always_ff @(posedge tau2015_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_p2  <= '0;
            rd_ptr_p2  <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr_p2 <= wr_ptr_p2 + PTR_ONE;
            if (pop)  rd_ptr_p2 <= rd_ptr_p2 + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky overflow and saturating drop counter; a same-cycle drop survives a clear.
    always_ff @(posedge tau2015_clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            overflow <= drop;
            drop_cnt <= drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // Fall-through read port: oldest entry shown, zero when empty.
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? mem_p2[rd_ptr_p2] : 3'b000;

endmodule
